muldiv_ctrl: RTL and testbench

Sequencer for a multi-cycle multiply/divide unit that sits beside the EXECUTE stage. It shares the ID/EX operand buses with the single-cycle ALU. It accepts MIPS mult/multu/div/divu requests from ID/EX and runs a 32-iteration shift-add multiply or restoring divide. While it works it stalls the front of the pipeline, then presents a 64-bit HI/LO result for one cycle with a done pulse.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the ID/EX stage and the multi-cycle multiply/divide sequencer.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, funct, rdata1, rdata2,
        input  stall, busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, funct, rdata1, rdata2,
        output stall, busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// MIPS mult/multu/div/divu sequencer: WIDTH-cycle shift-add multiply or restoring divide on magnitudes,
// sign fix-up on the last iteration, one-cycle done pulse with HI/LO.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               valid_op;
    logic               accept;
    logic               op_div;
    logic               op_signed;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               dbz;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH:0]     div_rem_next;
    logic [WIDTH-1:0]   div_q_next;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Request decode and operand magnitudes, only meaningful in the IDLE accept cycle.
    always_comb begin
        valid_op  = (bus.funct[5:2] == 4'b0110);
        accept    = bus.start & valid_op;
        op_div    = bus.funct[1];
        op_signed = ~bus.funct[0];
        neg_a     = op_signed & bus.rdata1[WIDTH-1];
        neg_b     = op_signed & bus.rdata2[WIDTH-1];
        mag_a     = neg_a ? -bus.rdata1 : bus.rdata1;
        mag_b     = neg_b ? -bus.rdata2 : bus.rdata2;
        dbz       = op_div & (bus.rdata2 == '0);
    end

    // One iteration of each algorithm; acc holds {partial product, remaining multiplier}
    // for multiply and {unused, dividend/quotient shift register} for divide.
    always_comb begin
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next     = {mul_sum, acc[WIDTH-1:1]};
        prod_fix     = neg_q ? -mul_next : mul_next;

        // A shifted remainder is always below twice the divisor, so bit WIDTH of the difference is its sign.
        div_shift    = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_diff     = div_shift - {1'b0, opb};
        div_rem_next = div_diff[WIDTH] ? div_shift : div_diff;
        div_q_next   = {acc[WIDTH-2:0], ~div_diff[WIDTH]};
        q_fix        = neg_q ? -div_q_next : div_q_next;
        r_fix        = neg_r ? -div_rem_next[WIDTH-1:0] : div_rem_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            rem    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= op_div;
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
                        opb    <= op_div ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                        rem    <= '0;
                        count  <= '0;
                        dbz_r  <= dbz;
                        busy_r <= 1'b1;
                        // Divide by zero never enters RUN; the result is fixed by the ISA convention.
                        if (dbz) begin
                            hi_r   <= bus.rdata1;
                            lo_r   <= '1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        rem <= div_rem_next;
                        acc <= {acc[2*WIDTH-1:WIDTH], div_q_next};
                    end else begin
                        acc <= mul_next;
                    end
                    if (count == CW'(WIDTH-1)) begin
                        if (is_div) begin
                            hi_r <= r_fix;
                            lo_r <= q_fix;
                        end else begin
                            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix[WIDTH-1:0];
                        end
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the consuming instruction advances together with done.
    assign bus.stall       = (state == RUN) | ((state == IDLE) & accept);
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed vector bench for muldiv_ctrl: result table plus reset, abort and ignored-request sequences.
module tb_muldiv_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_if #(.WIDTH(WIDTH)) bus();

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          glitch;
    } vec_t;

    vec_t vecs[14];

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one op, optionally pulses a competing start at RUN cycle glitch_at, then checks timing and result.
    task automatic applyStimulus(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz,
                                 input int glitch_at);
        int exp_lat;
        int k;
        int stall_cnt;
        bit seen;
        exp_lat = (f[1] && b == 32'd0) ? 1 : WIDTH + 1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct  = f;
        bus.rdata1 = a;
        bus.rdata2 = b;
        #1;
        checkOutput({name, " stall_at_accept"}, 64'(bus.stall), 64'd1);
        stall_cnt = 1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            bus.start  = 1'b0;
            bus.funct  = F_ADD;
            bus.rdata1 = $urandom;
            bus.rdata2 = $urandom;
            if (k == glitch_at) begin
                bus.start = 1'b1;
                bus.funct = F_MULTU;
            end
            #1;
            if (bus.done)
                seen = 1'b1;
            else if (bus.stall)
                stall_cnt++;
        end
        bus.start = 1'b0;
        checkOutput({name, " latency"}, 64'(k), 64'(exp_lat));
        checkOutput({name, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
        checkOutput({name, " stall_in_done"}, 64'(bus.stall), 64'd0);
        checkOutput({name, " busy_in_done"}, 64'(bus.busy), 64'd1);
        checkOutput({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
        checkOutput({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
        checkOutput({name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        @(negedge clk);
        #1;
        checkOutput({name, " done_pulse_end"}, 64'(bus.done), 64'd0);
        checkOutput({name, " busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int seen_done;
        checks = 0;
        errors = 0;

        vecs[0]  = '{F_MULTU, 32'd10,         32'd20,         32'h0000_0000, 32'd200,       1'b0, 0};
        vecs[1]  = '{F_MULT,  32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0};
        vecs[2]  = '{F_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, 0};
        vecs[3]  = '{F_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0};
        vecs[4]  = '{F_DIVU,  32'd100,        32'd16,         32'd4,         32'd6,         1'b0, 5};
        vecs[5]  = '{F_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, 0};
        vecs[6]  = '{F_DIVU,  32'd55,         32'd0,          32'd55,        32'hFFFF_FFFF, 1'b1, 0};
        vecs[7]  = '{F_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0};
        vecs[8]  = '{F_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 1'b0, 0};
        vecs[9]  = '{F_DIVU,  32'hFFFF_FFFF,  32'd1,          32'd0,         32'hFFFF_FFFF, 1'b0, 0};
        vecs[10] = '{F_MULT,  32'd0,          32'd12345,      32'd0,         32'd0,         1'b0, 0};
        vecs[11] = '{F_DIV,   32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[12] = '{F_MULTU, 32'd3,          32'd4,          32'd0,         32'd12,        1'b0, 0};
        vecs[13] = '{F_DIVU,  32'd1000,       32'd7,          32'd6,         32'd142,       1'b0, 20};

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.funct  = F_ADD;
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset stall", 64'(bus.stall), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset hi", 64'(bus.hi), 64'd0);
        checkOutput("reset lo", 64'(bus.lo), 64'd0);
        checkOutput("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;

        // A start with an ALU funct (or an unrelated 0111xx funct) must neither stall nor launch.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct  = F_ADD;
        bus.rdata1 = 32'd9;
        bus.rdata2 = 32'd3;
        #1;
        checkOutput("nonmuldiv stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.funct = 6'b011100;
        #1;
        checkOutput("nonmuldiv busy", 64'(bus.busy), 64'd0);
        checkOutput("funct011100 stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.done || bus.busy) seen_done++;
            @(negedge clk);
        end
        checkOutput("nonmuldiv no_activity", 64'(seen_done), 64'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                          vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].glitch);
        end

        // Abort a mult at RUN iteration 10 with a one-edge reset.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct  = F_MULT;
        bus.rdata1 = 32'd5;
        bus.rdata2 = 32'hFFFF_FFFA;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.funct = F_ADD;
        end
        #1;
        checkOutput("abort busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort hi", 64'(bus.hi), 64'd0);
        checkOutput("abort lo", 64'(bus.lo), 64'd0);
        checkOutput("abort done", 64'(bus.done), 64'd0);
        checkOutput("abort stall", 64'(bus.stall), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        checkOutput("abort no_done", 64'(seen_done), 64'd0);
        applyStimulus("post_abort multu", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
